ahb_burst_arbiter: RTL and testbench

AHB_BURST_ARBITER -- requirements
Module: ahb_burst_arbiter

---
 rtl/ahb_burst_arbiter_if.sv | 27 ++
 rtl/ahb_burst_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ahb_burst_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_burst_arbiter_if.sv
// Bus-side signal bundle for ahb_burst_arbiter: request/transfer inputs from the
// currently muxed owner and the registered grant outputs back to the masters.
interface ahb_burst_arbiter_if #(
   parameter int MASTER_NUM = 4
);
   localparam int MW = $clog2(MASTER_NUM);

   // hready qualifies htrans/hburst of the owner; a transfer completes only when hready=1.
   logic [MASTER_NUM-1:0] hreq;
   logic [1:0]            htrans;
   logic [2:0]            hburst;
   logic                  hready;
   logic [MASTER_NUM-1:0] hgrant;
   logic [MW-1:0]         hmaster;
   logic                  hsel;
   logic                  hlast;

   modport master (
      output hreq, htrans, hburst, hready,
      input  hgrant, hmaster, hsel, hlast
   );

   modport slave (
      input  hreq, htrans, hburst, hready,
      output hgrant, hmaster, hsel, hlast
   );
endinterface

// File: rtl/ahb_burst_arbiter.sv
// Burst-aware AHB bus arbiter: fixed-priority or round-robin, holds grant for bursts.
// Optional macro AHB_ARB_INCR_LIMIT_EN: forces re-arbitration of long INCR bursts.
module ahb_burst_arbiter #(
   parameter int MASTER_NUM = 4,
   parameter int ARB_MODE   = 0
) (
   input  logic                          hclk,
   input  logic                          hreset_n,
   ahb_burst_arbiter_if.slave            bus,
   output logic [1:0]                    dbg_state,
   output logic [$clog2(MASTER_NUM)-1:0] dbg_rr_ptr
);
   localparam int MW = $clog2(MASTER_NUM);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BURST = 2'd2
   } state_e;

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_BUSY   = 2'd1;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;
   localparam logic [2:0] BT_SINGLE = 3'd0;
   localparam logic [2:0] BT_INCR   = 3'd1;

   state_e                state;
   logic [3:0]            beat_cnt;
   logic                  incr_mode;
   logic [MW-1:0]         rr_ptr;
   logic [MASTER_NUM-1:0] hgrant_q;
   logic [MW-1:0]         hmaster_q;

   logic                  do_arb;
   logic                  use_masked;
   logic                  start_burst;
   logic                  end_burst;
   logic                  owner_req;
   logic [MASTER_NUM-1:0] arb_req;
   logic [MW:0]           arb_res;
   logic                  arb_found;
   logic [MW-1:0]         arb_idx;

   // Returns {found, index}; round-robin starts at start and wraps.
   function automatic logic [MW:0] pick(input logic [MASTER_NUM-1:0] req,
                                        input logic [MW-1:0]         start);
      logic [MW:0]   res;
      logic [MW-1:0] p;
      res = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (ARB_MODE == 1) p = MW'((int'(start) + i) % MASTER_NUM);
         else               p = MW'(i);
         if (!res[MW] && req[p]) res = {1'b1, p};
      end
      return res;
   endfunction

   function automatic logic [3:0] len_m1(input logic [2:0] b);
      case (b)
         3'd2, 3'd3: len_m1 = 4'd3;
         3'd4, 3'd5: len_m1 = 4'd7;
         default:    len_m1 = 4'd15;
      endcase
   endfunction

   assign owner_req = bus.hreq[hmaster_q];

   always_comb begin
      do_arb      = 1'b0;
      use_masked  = 1'b0;
      start_burst = 1'b0;
      end_burst   = 1'b0;
      case (state)
         ST_IDLE: do_arb = 1'b1;
         ST_GRANT: begin
            if (bus.hready) begin
               if (bus.htrans == TR_NONSEQ) begin
                  if (bus.hburst == BT_SINGLE) do_arb = 1'b1;
                  else                         start_burst = 1'b1;
               end else if (bus.htrans == TR_IDLE || !owner_req) begin
                  do_arb = 1'b1;
               end
            end
         end
         ST_BURST: begin
            if (bus.hready) begin
               case (bus.htrans)
                  TR_IDLE: do_arb = 1'b1;
                  TR_NONSEQ: begin
                     if (bus.hburst == BT_SINGLE) end_burst = 1'b1;
                     else                         start_burst = 1'b1;
                  end
                  TR_SEQ: begin
                     if (incr_mode) begin
`ifdef AHB_ARB_INCR_LIMIT_EN
                        // beat_cnt holds completed beats minus one, so >=14 here means beat 16 or later.
                        if (beat_cnt >= 4'd14 && |(bus.hreq & ~hgrant_q)) begin
                           do_arb     = 1'b1;
                           use_masked = 1'b1;
                        end
`endif
                     end else if (beat_cnt == 4'd1) begin
                        do_arb = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: do_arb = 1'b1;
      endcase
   end

   assign arb_req   = use_masked ? (bus.hreq & ~hgrant_q) : bus.hreq;
   assign arb_res   = pick(arb_req, rr_ptr);
   assign arb_found = arb_res[MW];
   assign arb_idx   = arb_res[MW-1:0];

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state     <= ST_IDLE;
         hgrant_q  <= '0;
         hmaster_q <= '0;
         beat_cnt  <= '0;
         incr_mode <= 1'b0;
         rr_ptr    <= '0;
      end else if (do_arb) begin
         beat_cnt  <= '0;
         incr_mode <= 1'b0;
         if (arb_found) begin
            state     <= ST_GRANT;
            hgrant_q  <= MASTER_NUM'(1) << arb_idx;
            hmaster_q <= arb_idx;
            rr_ptr    <= (arb_idx == MW'(MASTER_NUM - 1)) ? '0 : arb_idx + MW'(1);
         end else begin
            state     <= ST_IDLE;
            hgrant_q  <= '0;
            hmaster_q <= '0;
         end
      end else if (start_burst) begin
         state <= ST_BURST;
         if (bus.hburst == BT_INCR) begin
            incr_mode <= 1'b1;
            beat_cnt  <= '0;
         end else begin
            incr_mode <= 1'b0;
            beat_cnt  <= len_m1(bus.hburst);
         end
      end else if (end_burst) begin
         state     <= ST_GRANT;
         incr_mode <= 1'b0;
         beat_cnt  <= '0;
      end else if (state == ST_BURST && bus.hready && bus.htrans == TR_SEQ) begin
         if (incr_mode) beat_cnt <= (beat_cnt == 4'd15) ? 4'd15 : beat_cnt + 4'd1;
         else           beat_cnt <= beat_cnt - 4'd1;
      end
   end

   assign bus.hgrant  = hgrant_q;
   assign bus.hmaster = hmaster_q;
   assign bus.hsel    = |hgrant_q;
   assign bus.hlast   = (state == ST_BURST) && !incr_mode && (beat_cnt == 4'd1) &&
                        (bus.htrans == TR_SEQ);
   assign dbg_state   = state;
   assign dbg_rr_ptr  = rr_ptr;
endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// Directed bench for ahb_burst_arbiter: fixed-priority instance driven from a vector
// table, round-robin instance driven by hand-written multi-cycle sequences.
module tb_ahb_burst_arbiter;
   logic       hclk;
   logic       rst0_n;
   logic       rst1_n;
   logic [1:0] st0, st1;
   logic [1:0] rr0, rr1;
   int         checks;
   int         errors;
   logic [3:0] exp_q[$];

   ahb_burst_arbiter_if #(.MASTER_NUM(4)) if0();
   ahb_burst_arbiter_if #(.MASTER_NUM(4)) if1();

   ahb_burst_arbiter #(.MASTER_NUM(4), .ARB_MODE(0)) dut0 (
      .hclk(hclk), .hreset_n(rst0_n), .bus(if0), .dbg_state(st0), .dbg_rr_ptr(rr0)
   );
   ahb_burst_arbiter #(.MASTER_NUM(4), .ARB_MODE(1)) dut1 (
      .hclk(hclk), .hreset_n(rst1_n), .bus(if1), .dbg_state(st1), .dbg_rr_ptr(rr1)
   );

   // clock / reset
   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   typedef struct {
      logic [3:0] req;
      logic [1:0] trans;
      logic [2:0] burst;
      logic       rdy;
      logic [3:0] gnt;
      logic [1:0] mst;
      logic       last;
      logic [1:0] st;
   } vec_t;

   vec_t vt[25];

   task automatic tick;
      @(posedge hclk);
      #1;
   endtask

   task automatic drive0(input logic [3:0] r, input logic [1:0] t, input logic [2:0] b,
                         input logic y);
      if0.hreq = r; if0.htrans = t; if0.hburst = b; if0.hready = y;
   endtask

   task automatic drive1(input logic [3:0] r, input logic [1:0] t, input logic [2:0] b,
                         input logic y);
      if1.hreq = r; if1.htrans = t; if1.hburst = b; if1.hready = y;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag, input logic [3:0] g, input logic [1:0] m,
                             input logic s, input logic l, input logic [1:0] st,
                             input logic [1:0] rr);
      check({tag, "_hgrant"}, 32'(g), 32'h0);
      check({tag, "_hmaster"}, 32'(m), 32'h0);
      check({tag, "_hsel"}, 32'(s), 32'h0);
      check({tag, "_hlast"}, 32'(l), 32'h0);
      check({tag, "_state"}, 32'(st), 32'h0);
      check({tag, "_rr_ptr"}, 32'(rr), 32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      drive0(4'b0000, 2'd0, 3'd0, 1'b1);
      drive1(4'b0000, 2'd0, 3'd0, 1'b1);

      // trans: 0 IDLE 1 BUSY 2 NONSEQ 3 SEQ; state: 0 IDLE 1 GRANT 2 BURST
      vt[0]  = '{4'b1010, 2'd0, 3'd0, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd1};
      vt[1]  = '{4'b1000, 2'd2, 3'd0, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd1};
      vt[2]  = '{4'b1001, 2'd2, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd2};
      vt[3]  = '{4'b1001, 2'd3, 3'd3, 1'b0, 4'b1000, 2'd3, 1'b0, 2'd2};
      vt[4]  = '{4'b1001, 2'd3, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd2};
      vt[5]  = '{4'b1001, 2'd1, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd2};
      vt[6]  = '{4'b1001, 2'd3, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd2};
      vt[7]  = '{4'b1001, 2'd3, 3'd3, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd2};
      vt[8]  = '{4'b1001, 2'd3, 3'd3, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd1};
      vt[9]  = '{4'b0101, 2'd2, 3'd4, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd2};
      vt[10] = '{4'b0101, 2'd3, 3'd4, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd2};
      vt[11] = '{4'b0101, 2'd3, 3'd4, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd2};
      vt[12] = '{4'b0100, 2'd0, 3'd4, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd1};
      vt[13] = '{4'b0100, 2'd0, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd1};
      vt[14] = '{4'b0000, 2'd0, 3'd0, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0};
      vt[15] = '{4'b0000, 2'd0, 3'd0, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0};
      vt[16] = '{4'b1100, 2'd0, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd1};
      vt[17] = '{4'b1100, 2'd1, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd1};
      vt[18] = '{4'b1000, 2'd1, 3'd0, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd1};
      vt[19] = '{4'b1000, 2'd2, 3'd7, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd2};
      vt[20] = '{4'b1001, 2'd3, 3'd7, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd2};
      vt[21] = '{4'b1001, 2'd2, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd2};
      vt[22] = '{4'b1001, 2'd3, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd2};
      vt[23] = '{4'b1001, 2'd3, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd2};
      vt[24] = '{4'b1001, 2'd3, 3'd3, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd1};

      #2;
      check_idle("reset0", if0.hgrant, if0.hmaster, if0.hsel, if0.hlast, st0, rr0);
      check_idle("reset1", if1.hgrant, if1.hmaster, if1.hsel, if1.hlast, st1, rr1);
      tick;
      tick;
      rst0_n = 1'b1;
      rst1_n = 1'b1;

      // table: fixed priority, bursts, early termination, restart, idle
      for (int i = 0; i < 25; i++) begin
         drive0(vt[i].req, vt[i].trans, vt[i].burst, vt[i].rdy);
         #1;
         check($sformatf("vec%0d_hlast", i), 32'(if0.hlast), 32'(vt[i].last));
         tick;
         check($sformatf("vec%0d_hgrant", i), 32'(if0.hgrant), 32'(vt[i].gnt));
         check($sformatf("vec%0d_hmaster", i), 32'(if0.hmaster), 32'(vt[i].mst));
         check($sformatf("vec%0d_hsel", i), 32'(if0.hsel), 32'(|vt[i].gnt));
         check($sformatf("vec%0d_state", i), 32'(st0), 32'(vt[i].st));
      end

      // INCR owner 1 for 20 beats while master 0 waits
      rst0_n = 1'b0;
      drive0(4'b0000, 2'd0, 3'd0, 1'b1);
      tick;
      rst0_n = 1'b1;
      drive0(4'b0010, 2'd0, 3'd0, 1'b1);
      tick;
      check("incr_first_grant", 32'(if0.hgrant), 32'h2);
      for (int b = 1; b <= 20; b++) begin
         logic [3:0] eg;
         drive0(4'b0011, (b == 1) ? 2'd2 : 2'd3, 3'd1, 1'b1);
         #1;
         check($sformatf("incr_beat%0d_hlast", b), 32'(if0.hlast), 32'h0);
         tick;
`ifdef AHB_ARB_INCR_LIMIT_EN
         eg = (b >= 16) ? 4'b0001 : 4'b0010;
`else
         eg = 4'b0010;
`endif
         check($sformatf("incr_beat%0d_hgrant", b), 32'(if0.hgrant), 32'(eg));
         if (eg == 4'b0001) break;
      end

      // round-robin rotation after a SINGLE
      drive1(4'b0100, 2'd0, 3'd0, 1'b1);
      tick;
      check("rr_first_grant", 32'(if1.hgrant), 32'h4);
      check("rr_ptr_after_m2", 32'(rr1), 32'h3);
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      for (int k = 0; k < 3; k++) begin
         logic [3:0] e;
         drive1(4'b1111, 2'd2, 3'd0, 1'b1);
         tick;
         e = exp_q.pop_front();
         check($sformatf("rr_single%0d_hgrant", k), 32'(if1.hgrant), 32'(e));
      end

      // reset in the middle of an INCR16 owned by master 1
      drive1(4'b1111, 2'd2, 3'd7, 1'b1);
      tick;
      check("rst_burst_state", 32'(st1), 32'h2);
      for (int b = 2; b <= 4; b++) begin
         drive1(4'b1111, 2'd3, 3'd7, 1'b1);
         tick;
      end
      check("rst_burst_owner", 32'(if1.hgrant), 32'h2);
      drive1(4'b1111, 2'd3, 3'd7, 1'b0);
      #2;
      rst1_n = 1'b0;
      #1;
      check_idle("mid_reset", if1.hgrant, if1.hmaster, if1.hsel, if1.hlast, st1, rr1);
      tick;
      rst1_n = 1'b1;
      drive1(4'b1111, 2'd0, 3'd0, 1'b1);
      tick;
      check("post_reset_hgrant", 32'(if1.hgrant), 32'h1);
      check("post_reset_rr_ptr", 32'(rr1), 32'h1);
      check("post_reset_state", 32'(st1), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
